// File: rtl/riscv_mem_pkg.sv
// Shared RV32I load/store definitions: funct3 codes, sequencer states,
// byte-count and legality helpers.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [2:0] byte_count(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return 3'd1;
      F3_H, F3_HU: return 3'd2;
      default:     return 3'd4;
    endcase
  endfunction

  // Unsigned variants exist only for loads.
  function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !we;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load result formatter: sign/zero extension of the
// assembled little-endian bytes according to funct3.
module load_extend
  import riscv_mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [31:0]     raw,
  output logic [XLEN-1:0] rdata
);

  always_comb begin
    rdata = '0;
    case (funct3)
      F3_B:    rdata = XLEN'($signed(raw[7:0]));
      F3_H:    rdata = XLEN'($signed(raw[15:0]));
      F3_BU:   rdata = XLEN'(raw[7:0]);
      F3_HU:   rdata = XLEN'(raw[15:0]);
      default: rdata = XLEN'(raw);
    endcase
  end

endmodule

// File: rtl/mem_byte_sequencer.sv
// Splits RV32I loads/stores into single-byte accesses on a byte-wide memory.
// Define MISALIGN_TRAP_EN to reject misaligned halfword/word requests.
module mem_byte_sequencer
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [XLEN-1:0]   rdata,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic [XLEN-1:0]   mem_wr_data,
  output logic              mem_sw,
  input  logic [XLEN-1:0]   mem_rd_data
);

  state_t            state;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       wdata_q;
  logic [2:0]        n_q;
  logic [1:0]        k_q;
  logic [31:0]       raw_q;
  logic [XLEN-1:0]   rdata_q;
  logic              err_q;

  logic              accept;
  logic              illegal;
  logic              last;
  logic              in_xfer;
  logic              store_active;
  logic [ADDR_W-1:0] cur_addr;
  logic [7:0]        wr_byte;
  logic [31:0]       raw_nxt;
  logic [XLEN-1:0]   ext_data;

  logic unused_bits;
  assign unused_bits = ^{mem_rd_data[XLEN-1:8], req_addr[XLEN-1:ADDR_W]};

  assign ready  = (state == IDLE);
  assign done   = (state == DONE);
  assign err    = err_q;
  assign rdata  = rdata_q;
  assign accept = req_valid && ready;

  always_comb begin
    illegal = !funct3_legal(req_we, req_funct3);
`ifdef MISALIGN_TRAP_EN
    if ((byte_count(req_funct3) == 3'd2 && req_addr[0]) ||
        (byte_count(req_funct3) == 3'd4 && req_addr[1:0] != 2'b00))
      illegal = 1'b1;
`endif
  end

  assign in_xfer  = (state == XFER);
  assign last     = ({1'b0, k_q} == n_q - 3'd1);
  assign cur_addr = base_q + ADDR_W'(k_q);
  assign wr_byte  = wdata_q[{k_q, 3'b000} +: 8];

  // The write strobe is gated by rst so an aborting reset suppresses the
  // byte that would otherwise be written on the very edge that resets us.
  assign store_active = in_xfer && we_q && !rst;

  assign mem_sw      = store_active;
  assign mem_wr_data = store_active ? XLEN'(wr_byte) : '0;
  assign mem_wr_addr = in_xfer ? cur_addr : '0;
  assign mem_rd_addr = in_xfer ? cur_addr : '0;

  always_comb begin
    raw_nxt = raw_q;
    raw_nxt[{k_q, 3'b000} +: 8] = mem_rd_data[7:0];
  end

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .funct3 (f3_q),
    .raw    (raw_nxt),
    .rdata  (ext_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      base_q  <= '0;
      wdata_q <= '0;
      n_q     <= '0;
      k_q     <= '0;
      raw_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (illegal) begin
              err_q <= 1'b1;
            end else begin
              state   <= XFER;
              we_q    <= req_we;
              f3_q    <= req_funct3;
              base_q  <= req_addr[ADDR_W-1:0];
              wdata_q <= req_wdata[31:0];
              n_q     <= byte_count(req_funct3);
              k_q     <= '0;
              raw_q   <= '0;
            end
          end
        end
        XFER: begin
          if (!we_q) raw_q <= raw_nxt;
          if (last) begin
            state   <= DONE;
            rdata_q <= we_q ? '0 : ext_data;
          end else begin
            k_q <= k_q + 2'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Self-checking bench for mem_byte_sequencer: directed scenarios plus random
// requests against a byte-array reference of the memory and load semantics.
module tb_mem_byte_sequencer;

  localparam int AW    = 5;
  localparam int XL    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [XL-1:0] req_addr;
  logic [XL-1:0] req_wdata;
  logic          ready;
  logic          done;
  logic          err;
  logic [XL-1:0] rdata;
  logic [AW-1:0] mem_wr_addr;
  logic [AW-1:0] mem_rd_addr;
  logic [XL-1:0] mem_wr_data;
  logic          mem_sw;
  logic [XL-1:0] mem_rd_data;

  logic [7:0] mem     [DEPTH];
  logic [7:0] ref_mem [DEPTH];
  logic [31:0] last_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_byte_sequencer #(.ADDR_W(AW), .XLEN(XL)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .ready       (ready),
    .done        (done),
    .err         (err),
    .rdata       (rdata),
    .mem_wr_addr (mem_wr_addr),
    .mem_rd_addr (mem_rd_addr),
    .mem_wr_data (mem_wr_data),
    .mem_sw      (mem_sw),
    .mem_rd_data (mem_rd_data)
  );

  assign mem_rd_data = {24'h0, mem[mem_rd_addr]};

  always @(posedge clk) begin
    if (mem_sw) mem[mem_wr_addr] <= mem_wr_data[7:0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_mem(input string tag);
    for (int i = 0; i < DEPTH; i++) chk(tag, {24'h0, mem[i]}, {24'h0, ref_mem[i]});
  endtask

  // One request, checked cycle by cycle from the accept edge to back-in-IDLE.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input bit hold);
    int unsigned n;
    int unsigned a;
    bit          illegal;
    logic [31:0] raw;
    logic [31:0] exp_rd;
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]);
`ifdef MISALIGN_TRAP_EN
    if ((n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00)) illegal = 1'b1;
`endif
    @(posedge clk); #1;
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    if (illegal) begin
      req_valid = 1'b0;
      @(negedge clk);
      chk("err_pulse", {31'h0, err}, 32'd1);
      chk("err_ready", {31'h0, ready}, 32'd1);
      chk("err_no_sw", {31'h0, mem_sw}, 32'd0);
      chk("err_no_done", {31'h0, done}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("err_cleared", {31'h0, err}, 32'd0);
      chk("err_still_no_done", {31'h0, done}, 32'd0);
      return;
    end
    raw = 32'h0;
    for (int k = 0; k < int'(n); k++) begin
      @(negedge clk);
      a = (addr + 32'(k)) % DEPTH;
      chk("xfer_ready", {31'h0, ready}, 32'd0);
      chk("xfer_done", {31'h0, done}, 32'd0);
      chk("xfer_sw", {31'h0, mem_sw}, {31'h0, we});
      chk("xfer_wr_addr", 32'(mem_wr_addr), a);
      chk("xfer_rd_addr", 32'(mem_rd_addr), a);
      chk("xfer_wr_data", mem_wr_data, we ? ((wd >> (8 * k)) & 32'hFF) : 32'h0);
      if (we) ref_mem[a] = 8'((wd >> (8 * k)) & 32'hFF);
      else    raw = raw + (32'(ref_mem[a]) << (8 * k));
      @(posedge clk);
    end
    if (we) exp_rd = 32'h0;
    else begin
      case (f3)
        3'd0: begin exp_rd = raw & 32'hFF;   if (exp_rd >= 32'h80)   exp_rd += 32'hFFFFFF00; end
        3'd1: begin exp_rd = raw & 32'hFFFF; if (exp_rd >= 32'h8000) exp_rd += 32'hFFFF0000; end
        3'd4: exp_rd = raw & 32'hFF;
        3'd5: exp_rd = raw & 32'hFFFF;
        default: exp_rd = raw;
      endcase
    end
    @(negedge clk);
    chk("done_pulse", {31'h0, done}, 32'd1);
    chk("done_ready", {31'h0, ready}, 32'd0);
    chk("done_sw", {31'h0, mem_sw}, 32'd0);
    chk("done_rdata", rdata, exp_rd);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("idle_ready", {31'h0, ready}, 32'd1);
    chk("idle_done", {31'h0, done}, 32'd0);
    chk("idle_rdata_held", rdata, exp_rd);
    last_rdata = exp_rd;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = '0; req_wdata = '0; last_rdata = 32'h0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'h0, ready}, 32'd1);
    chk("rst_done", {31'h0, done}, 32'd0);
    chk("rst_err", {31'h0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_sw", {31'h0, mem_sw}, 32'd0);
    chk("rst_wr_addr", 32'(mem_wr_addr), 32'd0);
    chk("rst_rd_addr", 32'(mem_rd_addr), 32'd0);
    chk("rst_wr_data", mem_wr_data, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // SW, LB/LBU sign vs zero, LH across the top of memory, LW wrap or trap
    run_req(1'b1, 3'b010, 32'd4, 32'hA1B2C3D4, 1'b0);
    chk_mem("sw_mem");
    chk("sw_byte7", {24'h0, mem[7]}, 32'hA1);
    run_req(1'b0, 3'b000, 32'd7, 32'h0, 1'b0);
    chk("lb_sext", last_rdata, 32'hFFFFFFA1);
    run_req(1'b0, 3'b100, 32'd7, 32'h0, 1'b0);
    chk("lbu_zext", last_rdata, 32'h000000A1);
    run_req(1'b1, 3'b001, 32'd30, 32'h00007F80, 1'b0);
    run_req(1'b0, 3'b001, 32'd30, 32'h0, 1'b0);
    chk("lh_30", last_rdata, 32'h00007F80);
    run_req(1'b0, 3'b010, 32'd30, 32'h0, 1'b0);
    chk_mem("lw_wrap_mem");

    run_req(1'b0, 3'b011, 32'd0, 32'h0, 1'b0);
    run_req(1'b1, 3'b100, 32'd2, 32'h55, 1'b0);
    run_req(1'b0, 3'b101, 32'd4, 32'h0, 1'b1);
    run_req(1'b1, 3'b000, 32'd12, 32'h5A, 1'b1);
    chk_mem("hold_mem");

    // Reset during the second XFER cycle of a word store
    @(posedge clk); #1;
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'd8; req_wdata = 32'h11223344;
    req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abort_first_sw", {31'h0, mem_sw}, 32'd1);
    chk("abort_first_addr", 32'(mem_wr_addr), 32'd8);
    ref_mem[8] = 8'h44;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_sw_gated", {31'h0, mem_sw}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", {31'h0, ready}, 32'd1);
    chk("abort_sw", {31'h0, mem_sw}, 32'd0);
    chk("abort_done", {31'h0, done}, 32'd0);
    chk("abort_rdata", rdata, 32'h0);
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_late_done", {31'h0, done}, 32'd0);
    end
    chk_mem("abort_mem");

    for (int t = 0; t < 60; t++) begin
      run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, 1'b0);
    end
    chk_mem("rand_mem");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_byte_sequencer.md
MEM_BYTE_SEQUENCER -- requirements
Module: mem_byte_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, meaning the byte-address width of the attached data memory.
REQ-002 SHALL have parameter XLEN, default 32, meaning the core data width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1, core load/store request.
REQ-006 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-007 SHALL have port req_funct3, input, 3, RV32I load/store funct3.
REQ-008 SHALL have port req_addr, input, XLEN, effective byte address; only [ADDR_W-1:0] is used.
REQ-009 SHALL have port req_wdata, input, XLEN, store data (rs2).
REQ-010 SHALL have port ready, output, 1, high when a request can be accepted.
REQ-011 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port err, output, 1, one-cycle pulse for a rejected request.
REQ-013 SHALL have port rdata, output, XLEN, extended load result.
REQ-014 SHALL have ports mem_wr_addr and mem_rd_addr, output, ADDR_W, memory byte addresses.
REQ-015 SHALL have port mem_wr_data, output, XLEN, store byte in [7:0] with zeros above.
REQ-016 SHALL have port mem_sw, output, 1, memory write strobe.
REQ-017 SHALL have port mem_rd_data, input, XLEN, combinational memory read data; only [7:0] is used.

Function
REQ-018 SHALL implement an FSM with states IDLE, XFER and DONE; ready = (state == IDLE).
REQ-019 SHALL accept a request on an edge where req_valid && ready, latching we, funct3, addr[ADDR_W-1:0] and wdata.
REQ-020 SHALL set the byte count N to 1 for funct3 000/100 (LB/LBU/SB), 2 for 001/101 (LH/LHU/SH), and 4 for 010 (LW/SW).
REQ-021 SHALL, when accepting an illegal funct3 (011, 110, 111; and 100/101 with we = 1), pulse err in the next cycle, stay in IDLE, and make no memory access.
REQ-022 SHALL stay exactly N cycles in XFER, with byte counter k = 0..N-1, then one cycle in DONE, then return to IDLE; total latency from accept edge to done is N+1 cycles.
REQ-023 SHALL drive mem_wr_addr = mem_rd_addr = (base + k) mod 2^ADDR_W during XFER, so address 31 + 1 wraps to 0; both are 0 outside XFER.
REQ-024 SHALL, for stores, drive mem_sw = 1 in every XFER cycle with mem_wr_data[7:0] = wdata[8k+7:8k] (little-endian); mem_sw and mem_wr_data are 0 otherwise.
REQ-025 SHALL, for loads, capture mem_rd_data[7:0] into result byte k at the end of each XFER cycle, with mem_sw held at 0.
REQ-026 SHALL in DONE present rdata sign-extended (LB, LH) or zero-extended (LBU, LHU), or the full word (LW); stores present rdata = 0.
REQ-027 SHALL hold rdata until the next accepted request; done is high only in DONE.
REQ-028 SHALL ignore req_valid while ready = 0; the requester must hold its request until it is accepted.

Reset
REQ-029 SHALL, with rst high at a clock edge, enter IDLE, clear the counter and latches, and take priority over any in-flight transfer, which is aborted.
REQ-030 SHALL present these values after reset: ready = 1, done = 0, err = 0, rdata = 0, mem_sw = 0, mem_wr_addr = 0, mem_rd_addr = 0, mem_wr_data = 0.

Configuration
REQ-031 SHALL, with MISALIGN_TRAP_EN defined, treat a halfword with addr[0] = 1 or a word with addr[1:0] != 0 as illegal according to REQ-021.
REQ-032 SHALL, without MISALIGN_TRAP_EN, perform misaligned accesses byte by byte according to REQ-023, including wrap-around.

Structure
REQ-033 SHALL take the funct3 constants, the byte-count function and the state enum from the shared package riscv_mem_pkg.
REQ-034 SHALL instantiate sub-module load_extend, a combinational unit that maps (funct3, 32-bit raw result) to rdata.

Verification
REQ-035 Bench SHALL cover reset followed by SW of 0xA1B2C3D4 at address 4: mem_sw high for 4 cycles, bytes D4, C3, B2, A1 written to addresses 4..7, done in cycle 5.
REQ-036 Bench SHALL cover LB at address 7 holding 0xA1: rdata = 0xFFFFFFA1; LBU at the same address: rdata = 0x000000A1; done in cycle 2.
REQ-037 Bench SHALL cover LH at address 30 holding 0x80, 0x7F at addresses 30 and 31: rdata = 0x00007F80, done in cycle 3.
REQ-038 Bench SHALL cover LW at address 30: without the macro, addresses 30, 31, 0, 1 are read (wrap); with MISALIGN_TRAP_EN, err pulses, mem_sw stays 0 and no done occurs.
REQ-039 Bench SHALL cover funct3 = 011, which causes an err pulse with no memory access, and req_valid held high during XFER, which is not re-accepted before done.
REQ-040 Bench SHALL cover rst asserted in the 2nd XFER cycle of SW 0x11223344 at address 8: the next cycle is IDLE with ready = 1, mem_sw = 0, no done, and only address 8 written.
